cp0_ctrl: RTL and testbench
===========================

# cp0_ctrl

Coprocessor-0 exception/interrupt controller for the pipelined MIPS core. It sits beside the M stage and owns SR, Cause, EPC and PRId. It decides when the pipeline must take an exception or interrupt, and drives `Req` and `EPC` into the next-PC logic. It records the victim context on entry and clears EXL when `eret` retires.

## Interface
Parameters:
- `PRID`, 32'h2206_0001: value returned for register 15.
- `EXC_INT`, 5'd0: ExcCode recorded for interrupts.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `A1` in 5: mfc0 read register number.
- `A2` in 5: mtc0 write register number.
- `Din` in 32: mtc0 write data.
- `we` in 1: mtc0 write enable.
- `M_pc` in 32: PC of the M-stage (victim) instruction.
- `BD` in 1: victim is in a branch delay slot.
- `ExcCode` in 5: pipeline-collected exception code; 0 means none.
- `HWInt` in 6: external interrupt lines, level-sensitive.
- `EXLClr` in 1: eret retiring in M.
- `Dout` out 32: read data for register A1.
- `EPC` out 32: exception return address, forwarded.
- `Req` out 1: take exception/interrupt this cycle; next PC becomes 0x0000_4180.

## Operation
Register layout. Unimplemented bits read 0; reads of unimplemented registers return 0.
- SR (12): IM[15:10], EXL[1], IE[0].
- Cause (13): BD[31], IP[15:10], ExcCode[6:2].
- EPC (14): full 32 bits, word-aligned.
- PRId (15): `PRID` constant.

Request logic (combinational):
- `int_req` = |(HWInt & IM) & IE & !EXL.
- `exc_req` = (ExcCode != 0) & !EXL.
- `Req` = `int_req` | `exc_req`.
- Interrupt has priority over exception.

On a clock edge with `Req`=1:
- EXL <= 1.
- Cause.BD <= BD.
- Cause.ExcCode <= `int_req` ? `EXC_INT` : ExcCode.
- EPC <= (BD ? M_pc-4 : M_pc) with bits [1:0] forced to 00.
- mtc0 in the same cycle is suppressed (victim instruction does not commit).

Every edge:
- Cause.IP <= HWInt, independent of Req and EXL.

mtc0 (`we`=1 and `Req`=0):
- A2=12 writes IM, EXL, IE only.
- A2=14 writes EPC with Din[31:2],2'b00.
- Cause and PRId are not writable; writes to them are ignored.

`EXLClr`=1 and `Req`=0: EXL <= 0. When both `EXLClr`=1 and an mtc0 to SR occur, EXLClr takes precedence for the EXL bit only.

`Dout`: combinational mux on A1 over the current register values. There is no write-through for SR or Cause.

`EPC` output:
- If `we` & A2==14 & !Req, output Din[31:2],2'b00; this lets an eret directly after an mtc0 see the new value.
- Otherwise output the EPC register.
- The consumer applies its own return offset.

## Timing
- Reset (`reset`=0, async): SR=0, Cause=0, EPC=0; `Req` forced 0 while reset is asserted; `Dout` follows A1 (0 or PRID).
- `Req` is valid in the same cycle as its inputs. Register effects appear on the next edge.
- EXL set blocks a second `Req` in the following cycle even if `HWInt` is still high.
- Level interrupt held through EXL: re-requests the first cycle after EXL clears, if IE and IM still enable it.
- `M_pc`=0 with `BD`=1 gives EPC=0xFFFF_FFFC (mod-2^32 wrap, no saturation).
- Reset deasserted mid-cycle: state stays at reset values until the first subsequent edge.

## Structure
- Shared package `cp0_pkg`:
  - register numbers SR=12, CAUSE=13, EPC=14, PRID=15;
  - bit-field positions (IM, EXL, IE, BD, IP, EXC);
  - handler address 32'h0000_4180;
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- Sub-module `cp0_req_arb`: combinational `int_req`/`exc_req`/priority/`Req` generation. Its outputs are also used for the ExcCode select.

## Test plan
- Reset low, then release: `Dout`(A1=12)=0, `Dout`(A1=15)=PRID, `Req`=0, `EPC`=0.
- mtc0 SR=0x0000_0401 then `HWInt`=6'b000001: `Req`=1 that cycle. Next edge gives EXL=1, Cause.ExcCode=0, Cause.IP[10]=1, and `Req`=0 the following cycle.
- `ExcCode`=12, `M_pc`=0x3008, `BD`=1, EXL=0: `Req`=1; after the edge, EPC=0x3004, Cause=0x8000_0030.
- Req with `we`=1, A2=14, Din=0x5555: the write is dropped and EPC holds the victim address.
- mtc0 EPC=0x3010 with `EXLClr`=1 in the next cycle: `EPC` output is 0x3010 in the write cycle (forwarded), and EXL=0 after the edge.
- `reset` asserted between edges while EXL=1: SR, Cause, EPC and `Req` drop to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception/interrupt controller: register numbers,
// field positions, handler address and exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_CODE_INT  = 5'd0,
        EXC_CODE_ADEL = 5'd4,
        EXC_CODE_ADES = 5'd5,
        EXC_CODE_RI   = 5'd10,
        EXC_CODE_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// Pipeline-side bus of the CP0 block: mfc0/mtc0 access, victim context, interrupt
// lines and the request/EPC results handed to the next-PC logic.
interface cp0_ctrl_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        we;
    logic [31:0] M_pc;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] Dout;
    logic [31:0] EPC;
    logic        Req;

    modport master (
        output A1, A2, Din, we, M_pc, BD, ExcCode, HWInt, EXLClr,
        input  Dout, EPC, Req
    );

    modport slave (
        input  A1, A2, Din, we, M_pc, BD, ExcCode, HWInt, EXLClr,
        output Dout, EPC, Req
    );
endinterface

// File: rtl/cp0_req_arb.sv
// Combinational request arbiter: interrupt vs exception, with interrupt winning
// the cause selection when both are pending.
module cp0_req_arb (
    input  logic       i_en,
    input  logic [5:0] i_hwint,
    input  logic [5:0] i_im,
    input  logic       i_ie,
    input  logic       i_exl,
    input  logic [4:0] i_exc_code,
    output logic       o_int_req,
    output logic       o_exc_req,
    output logic       o_sel_int,
    output logic       o_req
);
    logic w_int_raw;
    logic w_exc_raw;

    assign w_int_raw = (|(i_hwint & i_im)) & i_ie & ~i_exl;
    assign w_exc_raw = (i_exc_code != 5'd0) & ~i_exl;

    // Held in reset, nothing may redirect the pipeline.
    assign o_int_req = i_en & w_int_raw;
    assign o_exc_req = i_en & w_exc_raw;
    assign o_sel_int = o_int_req;
    assign o_req     = o_int_req | o_exc_req;
endmodule

// File: rtl/cp0_ctrl.sv
// CP0 controller: owns SR, Cause, EPC and PRId, records the victim context when a
// request is taken and clears EXL on eret.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h2206_0001,
    parameter logic [4:0]  EXC_INT = 5'd0
) (
    input  logic         clk,
    input  logic         reset,
    cp0_ctrl_if.slave    bus
);
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_sel_int;
    logic        w_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_victim_pc;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_dout;

    cp0_req_arb u_arb (
        .i_en       (reset),
        .i_hwint    (bus.HWInt),
        .i_im       (r_im),
        .i_ie       (r_ie),
        .i_exl      (r_exl),
        .i_exc_code (bus.ExcCode),
        .o_int_req  (w_int_req),
        .o_exc_req  (w_exc_req),
        .o_sel_int  (w_sel_int),
        .o_req      (w_req)
    );

    // A taken request squashes the victim, so its mtc0 must not commit.
    assign w_wr_sr     = bus.we & (bus.A2 == REG_SR)  & ~w_req;
    assign w_wr_epc    = bus.we & (bus.A2 == REG_EPC) & ~w_req;
    assign w_victim_pc = bus.BD ? (bus.M_pc - 32'd4) : bus.M_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_bd  <= 1'b0;
            r_ip  <= '0;
            r_exc <= '0;
            r_epc <= '0;
        end else begin
            r_ip <= bus.HWInt;
            if (w_req) begin
                r_exl <= 1'b1;
                r_bd  <= bus.BD;
                r_exc <= w_sel_int ? EXC_INT : bus.ExcCode;
                r_epc <= word_align(w_victim_pc);
            end else begin
                if (w_wr_sr) begin
                    r_im <= bus.Din[IM_HI:IM_LO];
                    r_ie <= bus.Din[IE_BIT];
                end
                // eret wins over an mtc0 for the EXL bit only.
                if (bus.EXLClr) begin
                    r_exl <= 1'b0;
                end else if (w_wr_sr) begin
                    r_exl <= bus.Din[EXL_BIT];
                end
                if (w_wr_epc) begin
                    r_epc <= word_align(bus.Din);
                end
            end
        end
    end

    always_comb begin
        w_sr                = '0;
        w_sr[IM_HI:IM_LO]   = r_im;
        w_sr[EXL_BIT]       = r_exl;
        w_sr[IE_BIT]        = r_ie;
        w_cause             = '0;
        w_cause[BD_BIT]     = r_bd;
        w_cause[IP_HI:IP_LO]   = r_ip;
        w_cause[EXC_HI:EXC_LO] = r_exc;
    end

    always_comb begin
        w_dout = '0;
        case (bus.A1)
            REG_SR:    w_dout = w_sr;
            REG_CAUSE: w_dout = w_cause;
            REG_EPC:   w_dout = r_epc;
            REG_PRID:  w_dout = PRID;
            default:   w_dout = '0;
        endcase
    end

    // Forwarding the pending EPC write lets an eret right after mtc0 see it.
    assign bus.EPC  = w_wr_epc ? word_align(bus.Din) : r_epc;
    assign bus.Dout = w_dout;
    assign bus.Req  = w_req;

    logic w_unused;
    assign w_unused = w_exc_req;
endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios plus randomized traffic
// compared against an architectural model of the CP0 registers.
module tb_cp0_ctrl;
    import cp0_pkg::*;

    localparam logic [31:0] PRID_V = 32'h2206_0001;

    logic clk = 1'b0;
    logic reset = 1'b0;

    cp0_ctrl_if bus();

    cp0_ctrl #(.PRID(PRID_V), .EXC_INT(5'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // architectural model state
    logic [5:0]  m_im;
    logic        m_exl;
    logic        m_ie;
    logic        m_bd;
    logic [5:0]  m_ip;
    logic [4:0]  m_exc;
    logic [31:0] m_epc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = '0; m_exc = '0; m_epc = '0;
    endtask

    function automatic logic m_int();
        return reset && (|(bus.HWInt & m_im)) && m_ie && !m_exl;
    endfunction

    function automatic logic m_req();
        return m_int() || (reset && bus.ExcCode != 5'd0 && !m_exl);
    endfunction

    function automatic logic [31:0] m_reg(input logic [4:0] a);
        case (a)
            5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'h0, m_ip, 3'h0, m_exc, 2'b00};
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_epc_out();
        if (bus.we && bus.A2 == 5'd14 && !m_req())
            return {bus.Din[31:2], 2'b00};
        return m_epc;
    endfunction

    task automatic drive(input logic we, input logic [4:0] a2, input logic [31:0] din,
                         input logic [5:0] hw, input logic [4:0] exc,
                         input logic [31:0] pc, input logic bd, input logic clr);
        bus.we = we; bus.A2 = a2; bus.Din = din; bus.HWInt = hw;
        bus.ExcCode = exc; bus.M_pc = pc; bus.BD = bd; bus.EXLClr = clr;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".req"},  {31'h0, bus.Req}, {31'h0, m_req()});
        chk({tag, ".epc"},  bus.EPC, m_epc_out());
        chk({tag, ".dout"}, bus.Dout, m_reg(bus.A1));
    endtask

    // Check combinational outputs mid-cycle, clock once, then advance the model.
    task automatic cycle(input string tag);
        logic req, irq;
        logic [31:0] vpc;
        #1;
        check_outs(tag);
        req = m_req();
        irq = m_int();
        @(posedge clk);
        if (reset) begin
            if (req) begin
                vpc   = bus.BD ? bus.M_pc - 32'd4 : bus.M_pc;
                m_exl = 1'b1;
                m_bd  = bus.BD;
                m_exc = irq ? 5'd0 : bus.ExcCode;
                m_epc = {vpc[31:2], 2'b00};
            end else begin
                if (bus.we && bus.A2 == 5'd12) begin
                    m_im  = bus.Din[15:10];
                    m_ie  = bus.Din[0];
                    m_exl = bus.Din[1];
                end
                if (bus.we && bus.A2 == 5'd14) m_epc = {bus.Din[31:2], 2'b00};
                if (bus.EXLClr) m_exl = 1'b0;
            end
            m_ip = bus.HWInt;
        end
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.A1 = a;
        #1;
        chk(tag, bus.Dout, exp);
        chk({tag, ".model"}, bus.Dout, m_reg(a));
    endtask

    initial begin
        m_reset();
        bus.A1 = 5'd12;
        drive(0, 0, 0, 6'h0, 5'd5, 32'h0, 0, 0);
        #2;
        chk("rst_req_forced0", {31'h0, bus.Req}, 32'h0);
        bus.ExcCode = 5'd0;
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_prid", 5'd15, PRID_V);
        chk("rst_req", {31'h0, bus.Req}, 32'h0);
        chk("rst_epc", bus.EPC, 32'h0);
        @(posedge clk); #1;

        // interrupt entry
        drive(1, 5'd12, 32'h0000_0401, 6'h0, 0, 32'h0, 0, 0);
        cycle("mtc0_sr");
        drive(0, 0, 0, 6'b000001, 0, 32'h2000, 0, 0);
        #1 chk("int_req_now", {31'h0, bus.Req}, 32'h1);
        cycle("int_take");
        rd("int_sr_exl", 5'd12, 32'h0000_0403);
        rd("int_cause", 5'd13, 32'h0000_0400);
        chk("int_exl_blocks", {31'h0, bus.Req}, 32'h0);
        cycle("int_hold");

        // exception in delay slot
        drive(1, 5'd12, 32'h0, 6'h0, 0, 32'h0, 0, 0);
        cycle("sr_clear");
        drive(0, 0, 0, 6'h0, 5'd12, 32'h3008, 1, 0);
        #1 chk("ov_req", {31'h0, bus.Req}, 32'h1);
        cycle("ov_take");
        rd("ov_epc", 5'd14, 32'h0000_3004);
        rd("ov_cause", 5'd13, 32'h8000_0030);

        // mtc0 EPC squashed by a taken request
        drive(0, 0, 0, 6'h0, 0, 32'h0, 0, 1);
        cycle("eret1");
        drive(1, 5'd14, 32'h5555, 6'h0, 5'd4, 32'h1000, 0, 0);
        #1 chk("sq_epc_out", bus.EPC, 32'h3004);
        cycle("sq_take");
        rd("sq_epc", 5'd14, 32'h0000_1000);

        // forwarded EPC then eret
        drive(1, 5'd14, 32'h3010, 6'h0, 0, 32'h0, 0, 0);
        #1 chk("fwd_epc_out", bus.EPC, 32'h3010);
        cycle("fwd_wr");
        drive(0, 0, 0, 6'h0, 0, 32'h0, 0, 1);
        cycle("fwd_eret");
        rd("fwd_sr", 5'd12, 32'h0);
        rd("fwd_epc_reg", 5'd14, 32'h3010);

        // EPC wrap below zero
        drive(0, 0, 0, 6'h0, 5'd10, 32'h0, 1, 0);
        cycle("wrap_take");
        rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        drive(0, 0, 0, 6'h0, 0, 32'h0, 0, 1);
        cycle("wrap_eret");

        // level interrupt re-requests after eret; eret + mtc0 SR precedence
        drive(1, 5'd12, 32'h0000_8001, 6'h0, 0, 32'h0, 0, 0);
        cycle("im5");
        drive(0, 0, 0, 6'b100000, 0, 32'h40, 0, 0);
        cycle("lvl_take");
        drive(1, 5'd12, 32'h0000_8003, 6'b100000, 0, 32'h44, 0, 1);
        #1 chk("lvl_blocked", {31'h0, bus.Req}, 32'h0);
        cycle("lvl_eret");
        rd("lvl_exl_clr", 5'd12, 32'h0000_8001);
        chk("lvl_rereq", {31'h0, bus.Req}, 32'h1);
        cycle("lvl_retake");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.A1 = 5'($urandom_range(11, 16));
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(11, 16)), $urandom,
                  6'($urandom), ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                  $urandom, 1'($urandom), $urandom_range(0, 3) == 0);
            cycle("rnd");
        end

        // async reset between edges with EXL set
        drive(0, 0, 0, 6'h0, 0, 32'h0, 0, 1);
        cycle("pre_eret");
        drive(0, 0, 0, 6'h0, 5'd5, 32'h1234, 0, 0);
        cycle("pre_exc");
        rd("pre_exl", 5'd12, m_reg(5'd12) | 32'h2);
        drive(0, 0, 0, 6'h3F, 5'd5, 32'h1234, 0, 0);
        reset = 1'b0;
        m_reset();
        #1 chk("arst_req", {31'h0, bus.Req}, 32'h0);
        chk("arst_epc_out", bus.EPC, 32'h0);
        rd("arst_sr", 5'd12, 32'h0);
        rd("arst_cause", 5'd13, 32'h0);
        rd("arst_epc", 5'd14, 32'h0);
        @(posedge clk); #3;
        reset = 1'b1;
        drive(0, 0, 0, 6'h0, 0, 32'h0, 0, 0);
        rd("rel_sr", 5'd12, 32'h0);
        rd("rel_cause", 5'd13, 32'h0);
        chk("rel_req", {31'h0, bus.Req}, 32'h0);
        @(posedge clk); #1;
        cycle("post_rel");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
